// File: rtl/ram_bus_arbiter_if.sv
// Bus bundle between the CPU/DMA requesters, the RAM arbiter and the RAM strobes.
// The arbiter takes the slave view; the requesters and RAM side take the master view.
interface ram_bus_arbiter_if;
    logic        creq;
    logic        cwr;
    logic [15:0] ca;
    logic        dreq;
    logic        dwr;
    logic [15:0] da;
    logic        cack;
    logic        dack;
    logic        cgnt;
    logic        dgnt;
    logic [15:0] ra;
    logic        ramcs;
    logic        ramwr;
    logic        miss;

    modport slave (
        input  creq, cwr, ca, dreq, dwr, da,
        output cack, dack, cgnt, dgnt, ra, ramcs, ramwr, miss
    );

    modport master (
        output creq, cwr, ca, dreq, dwr, da,
        input  cack, dack, cgnt, dgnt, ra, ramcs, ramwr, miss
    );
endinterface

// File: rtl/ram_bus_arbiter.sv
// Round-robin arbiter sharing one static-RAM port between CPU and DMA, sequencing
// each access as SETUP / STROBE / HOLD with registered active-low RAMCS and RAMWR.
module ram_bus_arbiter #(
    parameter int unsigned WAIT_CYCLES = 2,
    parameter logic [15:0] RAM_TOP     = 16'h2FFF
) (
    input logic              clk,
    input logic              rst,
    ram_bus_arbiter_if.slave bus
);

    generate
        if (WAIT_CYCLES < 1 || WAIT_CYCLES > 15) begin : g_bad_wait
            $error("ram_bus_arbiter: WAIT_CYCLES must be in 1..15");
        end
    endgenerate

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        STROBE,
        HOLD,
        MISSACK
    } state_t;

    localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);

    state_t      state;
    logic [3:0]  cnt;
    logic        wr_q;
    logic        owner_dma;
    logic        last_dma;

    logic        pick_any;
    logic        pick_dma;
    logic [15:0] pick_addr;
    logic        pick_wr;

    // On a tie the requester that did not win last time takes the port.
    assign pick_any  = bus.creq | bus.dreq;
    assign pick_dma  = bus.dreq & (~bus.creq | ~last_dma);
    assign pick_addr = pick_dma ? bus.da  : bus.ca;
    assign pick_wr   = pick_dma ? bus.dwr : bus.cwr;

    // NOTE: every register here uses <= so all of them update from the same
    // pre-edge values; blocking assignments would let later lines see new values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            wr_q      <= 1'b0;
            owner_dma <= 1'b0;
            last_dma  <= 1'b1;
            bus.ra    <= '0;
            bus.ramcs <= 1'b1;
            bus.ramwr <= 1'b1;
            bus.cgnt  <= 1'b0;
            bus.dgnt  <= 1'b0;
            bus.cack  <= 1'b0;
            bus.dack  <= 1'b0;
            bus.miss  <= 1'b0;
        end else begin
            bus.cack <= 1'b0;
            bus.dack <= 1'b0;
            bus.miss <= 1'b0;

            case (state)
                IDLE: begin
                    if (pick_any) begin
                        owner_dma <= pick_dma;
                        wr_q      <= pick_wr;
                        if (pick_addr > RAM_TOP) begin
                            // Out-of-window: RA keeps its old value, RAM is never selected.
                            state <= MISSACK;
                        end else begin
                            bus.ra    <= pick_addr;
                            bus.cgnt  <= ~pick_dma;
                            bus.dgnt  <= pick_dma;
                            bus.ramcs <= 1'b0;
                            bus.ramwr <= 1'b1;
                            state     <= SETUP;
                        end
                    end
                end

                SETUP: begin
                    cnt       <= CNT_LOAD;
                    bus.ramwr <= ~wr_q;
                    state     <= STROBE;
                end

                STROBE: begin
                    if (cnt == 4'd0) begin
                        bus.ramwr <= 1'b1;
                        state     <= HOLD;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end

                HOLD: begin
                    bus.ramcs <= 1'b1;
                    bus.cgnt  <= 1'b0;
                    bus.dgnt  <= 1'b0;
                    bus.cack  <= ~owner_dma;
                    bus.dack  <= owner_dma;
                    last_dma  <= owner_dma;
                    state     <= IDLE;
                end

                MISSACK: begin
                    bus.cack <= ~owner_dma;
                    bus.dack <= owner_dma;
                    bus.miss <= 1'b1;
                    last_dma <= owner_dma;
                    state    <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_bus_arbiter.sv
// Directed bench for ram_bus_arbiter with WAIT_CYCLES=2 and RAM_TOP=16'h2FFF:
// reset, CPU write timing, tie alternation, miss, async abort and latched stability.
module tb_ram_bus_arbiter;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    ram_bus_arbiter_if bus ();

    ram_bus_arbiter #(
        .WAIT_CYCLES(2),
        .RAM_TOP    (16'h2FFF)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.creq = i[0];
            bus.dreq = ~i[0];
            bus.cwr  = 1'b1;
            bus.dwr  = i[1];
            bus.ca   = 16'h0100 + 16'(i);
            bus.da   = 16'h0200 + 16'(i);
            step();
            checks++;
            if (bus.ramcs !== 1'b1 || bus.ramwr !== 1'b1) begin
                errors++;
                $display("FAIL reset_strobes cycle %0d: got cs=%b wr=%b want cs=1 wr=1", i, bus.ramcs, bus.ramwr);
            end
            checks++;
            if ({bus.cgnt, bus.dgnt, bus.cack, bus.dack, bus.miss} !== 5'b0) begin
                errors++;
                $display("FAIL reset_flags cycle %0d: got gnt/ack/miss=%b want 00000", i,
                         {bus.cgnt, bus.dgnt, bus.cack, bus.dack, bus.miss});
            end
            checks++;
            if (bus.ra !== 16'h0000) begin
                errors++;
                $display("FAIL reset_ra cycle %0d: got %h want 0000", i, bus.ra);
            end
        end
        bus.creq = 1'b0;
        bus.dreq = 1'b0;
        rst      = 1'b0;
        step();
    endtask

    task automatic test_cpu_write();
        int cs_low;
        int wr_low;
        int ack_at;
        int dack_seen;
        cs_low    = 0;
        wr_low    = 0;
        ack_at    = -1;
        dack_seen = 0;
        bus.creq = 1'b1;
        bus.cwr  = 1'b1;
        bus.ca   = 16'h1234;
        for (int i = 0; i < 8; i++) begin
            step();
            if (i == 0) begin
                checks++;
                if (bus.ra !== 16'h1234 || bus.cgnt !== 1'b1 || bus.dgnt !== 1'b0) begin
                    errors++;
                    $display("FAIL write_setup: got ra=%h cgnt=%b dgnt=%b want ra=1234 cgnt=1 dgnt=0",
                             bus.ra, bus.cgnt, bus.dgnt);
                end
            end
            if (bus.ramcs === 1'b0) cs_low++;
            if (bus.ramwr === 1'b0) wr_low++;
            if (bus.dack === 1'b1) dack_seen++;
            if (bus.cack === 1'b1) begin
                if (ack_at < 0) ack_at = i;
                bus.creq = 1'b0;
            end
        end
        checks++;
        if (cs_low != 4) begin
            errors++;
            $display("FAIL write_cs_len: got %0d want 4", cs_low);
        end
        checks++;
        if (wr_low != 2) begin
            errors++;
            $display("FAIL write_wr_len: got %0d want 2", wr_low);
        end
        checks++;
        if (ack_at != 4) begin
            errors++;
            $display("FAIL write_ack_latency: got %0d want 4", ack_at);
        end
        checks++;
        if (dack_seen != 0) begin
            errors++;
            $display("FAIL write_no_dack: got %0d want 0", dack_seen);
        end
        bus.creq = 1'b0;
    endtask

    task automatic test_tie();
        int         nack;
        logic [3:0] got_dma;
        nack    = 0;
        got_dma = '0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        bus.creq = 1'b1;
        bus.cwr  = 1'b0;
        bus.ca   = 16'h0100;
        bus.dreq = 1'b1;
        bus.dwr  = 1'b1;
        bus.da   = 16'h0200;
        for (int i = 0; i < 40 && nack < 4; i++) begin
            step();
            checks++;
            if (bus.cgnt === 1'b1 && bus.dgnt === 1'b1) begin
                errors++;
                $display("FAIL tie_both_gnt cycle %0d: got cgnt=1 dgnt=1 want exclusive", i);
            end
            if (bus.cgnt === 1'b1) begin
                checks++;
                if (bus.ra !== 16'h0100 || bus.ramwr !== 1'b1) begin
                    errors++;
                    $display("FAIL tie_cpu_read cycle %0d: got ra=%h wr=%b want ra=0100 wr=1", i, bus.ra, bus.ramwr);
                end
            end
            if (bus.dgnt === 1'b1) begin
                checks++;
                if (bus.ra !== 16'h0200) begin
                    errors++;
                    $display("FAIL tie_dma_addr cycle %0d: got %h want 0200", i, bus.ra);
                end
            end
            if (bus.cack === 1'b1 || bus.dack === 1'b1) begin
                got_dma[nack] = bus.dack;
                nack++;
            end
        end
        bus.creq = 1'b0;
        bus.dreq = 1'b0;
        checks++;
        if (nack != 4) begin
            errors++;
            $display("FAIL tie_ack_count: got %0d want 4", nack);
        end
        checks++;
        if (got_dma !== 4'b1010) begin
            errors++;
            $display("FAIL tie_order: got dma-winner bits %b want 1010 (C,D,C,D)", got_dma);
        end
    endtask

    task automatic test_miss();
        bus.dreq = 1'b1;
        bus.dwr  = 1'b1;
        bus.da   = 16'h3000;
        step();
        checks++;
        if (bus.dack !== 1'b0 || bus.ramcs !== 1'b1 || bus.dgnt !== 1'b0) begin
            errors++;
            $display("FAIL miss_first: got dack=%b cs=%b dgnt=%b want 0 1 0", bus.dack, bus.ramcs, bus.dgnt);
        end
        step();
        checks++;
        if (bus.dack !== 1'b1 || bus.miss !== 1'b1 || bus.cack !== 1'b0) begin
            errors++;
            $display("FAIL miss_ack: got dack=%b miss=%b cack=%b want 1 1 0", bus.dack, bus.miss, bus.cack);
        end
        checks++;
        if (bus.ramcs !== 1'b1 || bus.ramwr !== 1'b1 || bus.ra !== 16'h0200) begin
            errors++;
            $display("FAIL miss_ram_idle: got cs=%b wr=%b ra=%h want 1 1 0200", bus.ramcs, bus.ramwr, bus.ra);
        end
        bus.dreq = 1'b0;
        step();
        checks++;
        if (bus.miss !== 1'b0 || bus.dack !== 1'b0) begin
            errors++;
            $display("FAIL miss_pulse_width: got miss=%b dack=%b want 0 0", bus.miss, bus.dack);
        end
    endtask

    task automatic test_abort();
        int ack_at;
        ack_at = -1;
        bus.creq = 1'b1;
        bus.cwr  = 1'b1;
        bus.ca   = 16'h0010;
        step();
        step();
        checks++;
        if (bus.ramwr !== 1'b0 || bus.ramcs !== 1'b0) begin
            errors++;
            $display("FAIL abort_in_strobe: got cs=%b wr=%b want 0 0", bus.ramcs, bus.ramwr);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (bus.ramwr !== 1'b1 || bus.ramcs !== 1'b1 || bus.cgnt !== 1'b0) begin
            errors++;
            $display("FAIL abort_async: got cs=%b wr=%b cgnt=%b want 1 1 0", bus.ramcs, bus.ramwr, bus.cgnt);
        end
        step();
        checks++;
        if (bus.cack !== 1'b0) begin
            errors++;
            $display("FAIL abort_no_ack: got %b want 0", bus.cack);
        end
        rst = 1'b0;
        step();
        checks++;
        if (bus.cgnt !== 1'b1 || bus.ramcs !== 1'b0 || bus.ramwr !== 1'b1) begin
            errors++;
            $display("FAIL abort_restart_setup: got cgnt=%b cs=%b wr=%b want 1 0 1", bus.cgnt, bus.ramcs, bus.ramwr);
        end
        for (int i = 1; i < 10 && ack_at < 0; i++) begin
            step();
            if (bus.cack === 1'b1) begin
                ack_at   = i;
                bus.creq = 1'b0;
            end
        end
        bus.creq = 1'b0;
        checks++;
        if (ack_at != 4) begin
            errors++;
            $display("FAIL abort_restart_ack: got %0d want 4", ack_at);
        end
    endtask

    task automatic test_stability();
        int acks;
        int misses;
        acks   = 0;
        misses = 0;
        bus.creq = 1'b1;
        bus.cwr  = 1'b1;
        bus.ca   = 16'h2FFF;
        step();
        checks++;
        if (bus.ra !== 16'h2FFF || bus.cgnt !== 1'b1) begin
            errors++;
            $display("FAIL stab_top_hit: got ra=%h cgnt=%b want 2fff 1", bus.ra, bus.cgnt);
        end
        step();
        checks++;
        if (bus.ramwr !== 1'b0) begin
            errors++;
            $display("FAIL stab_wr_low: got %b want 0", bus.ramwr);
        end
        bus.ca   = 16'h0055;
        bus.cwr  = 1'b0;
        bus.creq = 1'b0;
        step();
        checks++;
        if (bus.ra !== 16'h2FFF || bus.ramwr !== 1'b0) begin
            errors++;
            $display("FAIL stab_latched: got ra=%h wr=%b want 2fff 0", bus.ra, bus.ramwr);
        end
        for (int i = 0; i < 8; i++) begin
            step();
            if (bus.cack === 1'b1) acks++;
            if (bus.miss === 1'b1 || bus.dack === 1'b1) misses++;
        end
        checks++;
        if (acks != 1) begin
            errors++;
            $display("FAIL stab_ack_once: got %0d want 1", acks);
        end
        checks++;
        if (misses != 0 || bus.ra !== 16'h2FFF) begin
            errors++;
            $display("FAIL stab_no_miss: got misses=%0d ra=%h want 0 2fff", misses, bus.ra);
        end
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        rst      = 1'b1;
        bus.creq = 1'b0;
        bus.cwr  = 1'b0;
        bus.ca   = '0;
        bus.dreq = 1'b0;
        bus.dwr  = 1'b0;
        bus.da   = '0;
        test_reset();
        test_cpu_write();
        test_tie();
        test_miss();
        test_abort();
        test_stability();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
